// File: rtl/dac_spi_multich.sv
// dac_spi_multich: scans the enabled channel words out to a SPI DAC, one chip-select frame per channel.
// Frame = DATA_W bits MSB first (sclk high then low per bit), a hold phase with sclk high, then a cs_n-high gap.
module dac_spi_multich #(
  parameter int DATA_W  = 16,
  parameter int NCH     = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  localparam int IDX_W  = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sending_start,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH*DATA_W-1:0]   ch_data,
  output logic                    busy,
  output logic                    sending_done,
  output logic [IDX_W-1:0]        ch_idx,
  output logic                    dac_cs_n,
  output logic                    dac_sclk,
  output logic                    dac_din
);
  localparam int CNT_MAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = DATA_W > 1 ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, GAP, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  ph_q, ph_d;
  logic [NCH-1:0]        en_q, en_d;
  logic [NCH*DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d, first_idx, next_idx;
  logic                  has_next, div_end, gap_end;
  logic [DATA_W-1:0]     word;

  // Descending scan leaves the lowest qualifying index in each result.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ch_en[k]) first_idx = IDX_W'(k);
      if (en_q[k] && IDX_W'(k) > idx_q) begin
        next_idx = IDX_W'(k);
        has_next = 1'b1;
      end
    end
  end

  assign div_end = cnt_q == CNT_W'(CLK_DIV - 1);
  assign gap_end = cnt_q == CNT_W'(CS_GAP - 1);
  assign word    = data_q[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    ph_d    = ph_q;
    en_d    = en_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sending_start) begin
          state_d = |ch_en ? SHIFT : DONE;
          if (|ch_en) begin
            en_d   = ch_en;
            data_d = ch_data;
            idx_d  = first_idx;
            bit_d  = BIT_W'(DATA_W - 1);
            ph_d   = 1'b0;
          end
        end
      end
      SHIFT: if (div_end) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
        if (ph_q) begin
          bit_d   = bit_q - BIT_W'(1);
          state_d = bit_q == '0 ? HOLD : SHIFT;
        end
      end
      HOLD: if (div_end) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (gap_end) begin
        cnt_d   = '0;
        state_d = has_next ? SHIFT : DONE;
        idx_d   = has_next ? next_idx : idx_q;
        bit_d   = BIT_W'(DATA_W - 1);
        ph_d    = 1'b0;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      en_q    <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      en_q    <= en_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign busy         = state_q == SHIFT || state_q == HOLD || state_q == GAP;
  assign sending_done = state_q == DONE;
  assign ch_idx       = idx_q;
  assign dac_cs_n     = !(state_q == SHIFT || state_q == HOLD);
  assign dac_sclk     = !(state_q == SHIFT && ph_q);
  assign dac_din      = state_q == SHIFT && word[bit_q];
endmodule

// File: tb/tb_dac_spi_multich.sv
// tb_dac_spi_multich: per-cycle comparison against a waveform model built from the frame rules,
// plus a DAC-side frame decoder and literal checks for the directed scenarios.
module tb_dac_spi_multich;
  localparam int DW = 16, NCH = 2, CD = 4, GP = 2, IW = 1;
  localparam int CS_LOW = (2*DW + 1) * CD;

  logic clk = 1'b0, rst_n = 1'b0, sending_start = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic busy, sending_done, dac_cs_n, dac_sclk, dac_din;
  logic [IW-1:0] ch_idx;

  dac_spi_multich #(.DATA_W(DW), .NCH(NCH), .CLK_DIV(CD), .CS_GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .sending_start(sending_start), .ch_en(ch_en), .ch_data(ch_data),
    .busy(busy), .sending_done(sending_done), .ch_idx(ch_idx),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din));

  always #5 clk = ~clk;

  typedef struct packed {logic cs; logic sclk; logic din; logic busy; logic done; logic [IW-1:0] idx;} exp_t;

  exp_t eq[$];
  logic [DW-1:0] fq[$], obs_w[$];
  logic [IW-1:0] obs_i[$];
  logic [IW-1:0] idx_m = '0;
  int errs = 0, checks = 0, cyc = 0, ndone = 0, t_fall = 0, t_done = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      if (errs < 40) $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // Expected output sequence for a whole scan, one entry per clk cycle after acceptance.
  function automatic void push_scan(logic [NCH-1:0] en, logic [NCH*DW-1:0] d);
    logic [DW-1:0] w;
    for (int k = 0; k < NCH; k++) if (en[k]) begin
      idx_m = IW'(k);
      w = d[k*DW +: DW];
      fq.push_back(w);
      for (int b = DW - 1; b >= 0; b--) begin
        repeat (CD) eq.push_back({1'b0, 1'b1, w[b], 1'b1, 1'b0, idx_m});
        repeat (CD) eq.push_back({1'b0, 1'b0, w[b], 1'b1, 1'b0, idx_m});
      end
      repeat (CD) eq.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, idx_m});
      repeat (GP) eq.push_back({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, idx_m});
    end
    eq.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, idx_m});
  endfunction

  exp_t e, a;
  logic was_idle, pcs = 1'b1, psclk = 1'b1;
  logic [DW-1:0] word;
  logic [IW-1:0] fidx;
  int low = 0, nfe = 0;

  always @(negedge clk) begin
    a = {dac_cs_n, dac_sclk, dac_din, busy, sending_done, ch_idx};
    was_idle = eq.size() == 0;
    if (!rst_n) begin
      eq.delete();
      fq.delete();
      idx_m = '0;
    end
    e = (!rst_n || was_idle) ? exp_t'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, idx_m}) : eq.pop_front();
    checks++;
    if (a !== e) begin
      errs++;
      if (errs < 40) $display("FAIL cycle %0d outputs{cs,sclk,din,busy,done,idx}: got %b expected %b", cyc, a, e);
    end
    if (rst_n && was_idle && sending_start) push_scan(ch_en, ch_data);
    if (sending_done) begin
      ndone++;
      t_done = cyc;
    end
    if (!rst_n) begin
      low = 0;
      nfe = 0;
    end else if (!dac_cs_n) begin
      if (pcs) t_fall = cyc;
      low++;
      fidx = ch_idx;
      if (psclk && !dac_sclk) begin
        word = {word[DW-2:0], dac_din};
        nfe++;
      end
    end else if (!pcs) begin
      chk("cs_low_cycles", low, CS_LOW);
      chk("falling_edges", nfe, DW);
      if (fq.size() == 0) chk("unexpected_frame", 1, 0);
      else chk("frame_word", word, fq.pop_front());
      obs_w.push_back(word);
      obs_i.push_back(fidx);
      low = 0;
      nfe = 0;
    end
    pcs = dac_cs_n;
    psclk = dac_sclk;
    cyc++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [NCH-1:0] en, input logic [NCH*DW-1:0] d);
    ch_en = en;
    ch_data = d;
    sending_start = 1'b1;
    cycle();
    sending_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (eq.size() == 0 && !busy && !sending_done) return;
      cycle();
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic chk_reset();
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_din", dac_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sending_done, 0);
    chk("rst_idx", ch_idx, 0);
  endtask

  task automatic clear_obs();
    obs_w.delete();
    obs_i.delete();
    ndone = 0;
  endtask

  int t0;

  initial begin
    repeat (3) cycle();
    chk_reset();
    rst_n = 1'b1;
    cycle();

    clear_obs();
    start(2'b11, {16'h4555, 16'hCAAA});
    wait_idle();
    chk("scan2_nframes", obs_w.size(), 2);
    if (obs_w.size() == 2) begin
      chk("scan2_w0", obs_w[0], 16'hCAAA);
      chk("scan2_i0", obs_i[0], 0);
      chk("scan2_w1", obs_w[1], 16'h4555);
      chk("scan2_i1", obs_i[1], 1);
    end
    chk("scan2_ndone", ndone, 1);

    clear_obs();
    start(2'b10, {16'h1555, 16'h0000});
    wait_idle();
    chk("skip_nframes", obs_w.size(), 1);
    if (obs_w.size() == 1) begin
      chk("skip_w", obs_w[0], 16'h1555);
      chk("skip_i", obs_i[0], 1);
    end
    chk("skip_done_latency", t_done - t_fall, 134);

    clear_obs();
    t0 = cyc;
    start(2'b00, {16'h1234, 16'h5678});
    wait_idle();
    chk("empty_done_latency", t_done - t0, 1);
    chk("empty_nframes", obs_w.size(), 0);
    chk("empty_ndone", ndone, 1);

    clear_obs();
    start(2'b11, {16'h2345, 16'h1357});
    repeat (40) cycle();
    sending_start = 1'b1;
    ch_data = {16'hF555, 16'hF555};
    cycle();
    sending_start = 1'b0;
    wait_idle();
    chk("ignore_nframes", obs_w.size(), 2);
    if (obs_w.size() == 2) begin
      chk("ignore_w0", obs_w[0], 16'h1357);
      chk("ignore_w1", obs_w[1], 16'h2345);
    end
    chk("ignore_ndone", ndone, 1);

    start(2'b11, {16'h0F0F, 16'hA5C3});
    repeat (66) cycle();
    chk("bit7_cs_low", dac_cs_n, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    clear_obs();
    start(2'b01, {16'h0000, 16'h3C3C});
    wait_idle();
    chk("post_rst_nframes", obs_w.size(), 1);
    if (obs_w.size() == 1) chk("post_rst_w", obs_w[0], 16'h3C3C);

    for (int n = 0; n < 25; n++) begin
      start(NCH'($urandom_range(0, 3)), {16'($urandom), 16'($urandom)});
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 200)) cycle();
        sending_start = 1'b1;
        ch_en = NCH'($urandom_range(0, 3));
        ch_data = {16'($urandom), 16'($urandom)};
        cycle();
        sending_start = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 150)) cycle();
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) cycle();
        rst_n = 1'b1;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) cycle();
    end

    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
